// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB first, parity, stop.
// One bit per tx_clk cycle; all outputs registered.
module uart_tx #(
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       tx_clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_serial
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t     state;
  state_t     state_n;
  logic [2:0] cnt;
  logic [2:0] cnt_n;
  logic [7:0] shreg;
  logic [7:0] shreg_n;
  logic       par;
  logic       par_n;
  logic       serial_n;
  logic       busy_n;

  always_ff @(posedge tx_clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      shreg     <= 8'd0;
      par       <= 1'b0;
      tx_serial <= 1'b1;
      tx_busy   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      shreg     <= shreg_n;
      par       <= par_n;
      tx_serial <= serial_n;
      tx_busy   <= busy_n;
    end
  end

  // Outputs are computed from the next state so the line
  // changes on the same edge the state does.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    shreg_n  = shreg;
    par_n    = par;
    serial_n = tx_serial;
    busy_n   = tx_busy;
    unique case (state)
      IDLE: begin
        serial_n = 1'b1;
        busy_n   = 1'b0;
        if (tx_start) begin
          state_n  = START;
          shreg_n  = tx_data;
          par_n    = (^tx_data) ^ PARITY_ODD;
          serial_n = 1'b0;
          busy_n   = 1'b1;
        end
      end
      START: begin
        state_n  = DATA;
        cnt_n    = 3'd0;
        serial_n = shreg[0];
        busy_n   = 1'b1;
      end
      DATA: begin
        busy_n = 1'b1;
        if (cnt == 3'd7) begin
          state_n  = PARITY;
          serial_n = par;
        end else begin
          cnt_n    = cnt + 3'd1;
          serial_n = shreg[cnt + 3'd1];
        end
      end
      PARITY: begin
        state_n  = STOP;
        serial_n = 1'b1;
        busy_n   = 1'b1;
      end
      STOP: begin
        if (tx_start) begin
          state_n  = START;
          shreg_n  = tx_data;
          par_n    = (^tx_data) ^ PARITY_ODD;
          serial_n = 1'b0;
          busy_n   = 1'b1;
        end else begin
          state_n  = IDLE;
          serial_n = 1'b1;
          busy_n   = 1'b0;
        end
      end
      default: begin
        state_n  = IDLE;
        serial_n = 1'b1;
        busy_n   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: even and odd parity instances
// driven in parallel, frames captured once per bit time.
module tb_uart_tx;

  logic       tx_clk = 1'b0;
  logic       reset = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_busy;
  logic       tx_serial;
  logic       busy_odd;
  logic       serial_odd;

  int checks = 0;
  int errors = 0;

  logic [10:0] w;
  logic [10:0] wo;
  logic [10:0] w2;
  logic [10:0] wo2;
  int          bc;
  int          bc2;

  always #5 tx_clk = ~tx_clk;

  uart_tx #(.PARITY_ODD(1'b0)) dut (
    .tx_clk   (tx_clk),
    .reset    (reset),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .tx_serial(tx_serial)
  );

  uart_tx #(.PARITY_ODD(1'b1)) dut_odd (
    .tx_clk   (tx_clk),
    .reset    (reset),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (busy_odd),
    .tx_serial(serial_odd)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic pulse(input logic [7:0] d);
    @(negedge tx_clk);
    tx_start = 1'b1;
    tx_data  = d;
    @(negedge tx_clk);
    tx_start = 1'b0;
  endtask

  // Starts at the negedge inside the start-bit cycle.
  task automatic capture(input int inj,
                         input logic [7:0] inj_data,
                         input bit pls,
                         output logic [10:0] fw,
                         output logic [10:0] fwo,
                         output int bcount);
    bcount = 0;
    fw = '0;
    fwo = '0;
    for (int i = 0; i < 11; i++) begin
      fw[i]  = tx_serial;
      fwo[i] = serial_odd;
      if (tx_busy === 1'b1) bcount++;
      if (i == inj) begin
        tx_data = inj_data;
        if (pls) tx_start = 1'b1;
      end
      if (pls && i == inj + 1) tx_start = 1'b0;
      @(negedge tx_clk);
    end
  endtask

  task automatic idle_run(input string tag, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (tx_serial !== 1'b1 || tx_busy !== 1'b0) bad++;
      @(negedge tx_clk);
    end
    chk(tag, 32'(bad), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "timeout");
  end

  initial begin
    #3 reset = 1'b1;
    #1;
    chk("rst_serial", 32'(tx_serial), 32'd1);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    @(negedge tx_clk);
    @(negedge tx_clk);
    reset = 1'b0;
    idle_run("rst_idle", 5);

    pulse(8'hA5);
    capture(2, 8'h00, 1'b0, w, wo, bc);
    chk("a5_frame", 32'(w), 32'(11'b10101001010));
    chk("a5_odd", 32'(wo), 32'(11'b11101001010));
    chk("a5_busy", 32'(bc), 32'd11);
    idle_run("a5_idle", 3);

    pulse(8'h01);
    capture(-1, 8'h00, 1'b0, w, wo, bc);
    chk("x01_frame", 32'(w), 32'(11'b11000000010));
    chk("x01_odd", 32'(wo), 32'(11'b10000000010));
    idle_run("x01_idle", 3);

    pulse(8'h3C);
    capture(3, 8'hFF, 1'b1, w, wo, bc);
    chk("ign_frame", 32'(w), 32'(11'b10001111000));
    chk("ign_busy", 32'(bc), 32'd11);
    idle_run("ign_idle", 15);

    @(negedge tx_clk);
    tx_start = 1'b1;
    tx_data  = 8'h55;
    @(negedge tx_clk);
    capture(5, 8'hAA, 1'b0, w, wo, bc);
    chk("b2b_frame1", 32'(w), 32'(11'b10010101010));
    chk("b2b_busy1", 32'(bc), 32'd11);
    chk("b2b_start", 32'(tx_serial), 32'd0);
    chk("b2b_busy_gap", 32'(tx_busy), 32'd1);
    tx_start = 1'b0;
    capture(-1, 8'h00, 1'b0, w2, wo2, bc2);
    chk("b2b_frame2", 32'(w2), 32'(11'b10101010100));
    chk("b2b_odd2", 32'(wo2), 32'(11'b11101010100));
    chk("b2b_busy2", 32'(bc2), 32'd11);
    idle_run("b2b_idle", 4);

    pulse(8'hE0);
    repeat (5) @(negedge tx_clk);
    chk("mid_d4", 32'(tx_serial), 32'd0);
    chk("mid_busy", 32'(tx_busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_serial", 32'(tx_serial), 32'd1);
    chk("mid_rst_busy", 32'(tx_busy), 32'd0);
    @(negedge tx_clk);
    reset = 1'b0;
    idle_run("mid_rst_idle", 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
